html_char_streamer: RTL and testbench

- Upstream stage of html_parser: fetches the HTML document byte-by-byte from a synchronous ROM and presents one character at a time on a valid/ready handshake.
- Hides the 1-cycle ROM read latency behind a 2-entry prefetch buffer, so html_parser can take one char per clock.
- Detects end of document (NUL byte or length limit) and reports it to the top-level control.

---
 rtl/html_char_streamer_pkg.sv | 23 ++
 rtl/html_char_streamer_char_fifo2.sv | 55 +++++
 rtl/html_char_streamer.sv | 173 +++++++++++++++++
 tb/tb_html_char_streamer.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/html_char_streamer_pkg.sv
// Shared constants and state encoding for the HTML character streamer.
// The character width comes from the `CHAR_BITES macro (default 8).
`ifndef CHAR_BITES
`define CHAR_BITES 8
`endif

package html_char_streamer_pkg;

   localparam int unsigned PKG_CHAR_W = `CHAR_BITES;

   localparam logic [PKG_CHAR_W-1:0] CHAR_NUL = PKG_CHAR_W'(8'h00);
   localparam logic [PKG_CHAR_W-1:0] CHAR_SP  = PKG_CHAR_W'(8'h20);
   localparam logic [PKG_CHAR_W-1:0] CHAR_TAB = PKG_CHAR_W'(8'h09);
   localparam logic [PKG_CHAR_W-1:0] CHAR_LF  = PKG_CHAR_W'(8'h0A);
   localparam logic [PKG_CHAR_W-1:0] CHAR_CR  = PKG_CHAR_W'(8'h0D);

   typedef enum logic [1:0] {StIdle, StFetch, StStream, StDone} state_e;

   function automatic logic is_ws(input logic [PKG_CHAR_W-1:0] c);
      return (c == CHAR_SP) || (c == CHAR_TAB) || (c == CHAR_LF) || (c == CHAR_CR);
   endfunction

endpackage

// File: rtl/html_char_streamer_char_fifo2.sv
// char_fifo2: 2-entry first-word-fall-through buffer with push/pop/count.
// Output data reads as zero whenever the buffer is empty.
module char_fifo2 #(
   parameter int unsigned W = 8
) (
   input  logic         i_clk,
   input  logic         i_rst_n,
   input  logic         i_flush,
   input  logic         i_push,
   input  logic [W-1:0] i_data,
   input  logic         i_pop,
   output logic [W-1:0] o_data,
   output logic         o_valid,
   output logic [1:0]   o_count
);

   logic [W-1:0] r_mem [2];
   logic         r_rd_ptr;
   logic         r_wr_ptr;
   logic [1:0]   r_count;
   logic         w_push;
   logic         w_pop;

   assign w_pop  = i_pop && (r_count != 2'd0);
   // A full buffer still accepts a push when the head leaves in the same cycle.
   assign w_push = i_push && ((r_count != 2'd2) || w_pop);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_mem[0] <= '0;
         r_mem[1] <= '0;
         r_rd_ptr <= 1'b0;
         r_wr_ptr <= 1'b0;
         r_count  <= 2'd0;
      end else if (i_flush) begin
         r_rd_ptr <= 1'b0;
         r_wr_ptr <= 1'b0;
         r_count  <= 2'd0;
      end else begin
         if (w_push) begin
            r_mem[r_wr_ptr] <= i_data;
            r_wr_ptr        <= ~r_wr_ptr;
         end
         if (w_pop) begin
            r_rd_ptr <= ~r_rd_ptr;
         end
         r_count <= r_count + 2'(w_push) - 2'(w_pop);
      end
   end

   assign o_valid = (r_count != 2'd0);
   assign o_data  = o_valid ? r_mem[r_rd_ptr] : '0;
   assign o_count = r_count;

endmodule

// File: rtl/html_char_streamer.sv
// Streams an HTML document from a 1-cycle-latency ROM onto a valid/ready char port.
// Define HTML_WS_COLLAPSE_EN to collapse whitespace runs into a single space.
module html_char_streamer
   import html_char_streamer_pkg::*;
#(
   parameter int unsigned CHAR_W  = `CHAR_BITES,
   parameter int unsigned ADDR_W  = 12,
   parameter int unsigned DOC_LEN = 4096
) (
   input  logic              i_clock,
   input  logic              i_resetn,
   input  logic              i_start,
   output logic [ADDR_W-1:0] o_rom_addr,
   input  logic [CHAR_W-1:0] i_rom_data,
   output logic [CHAR_W-1:0] o_char,
   output logic              o_char_valid,
   input  logic              i_char_ready,
   output logic              o_eof,
   output logic              o_busy
);

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DOC_LEN - 1);

   state_e            r_state;
   logic [ADDR_W-1:0] r_addr;
   logic              r_inflight;
   logic              r_inflight_last;
   logic              r_last_issued;
   logic              r_end_seen;
   logic              r_eof;
   logic              r_busy;

   logic              w_active;
   logic              w_pop;
   logic              w_ret;
   logic              w_ret_nul;
   logic              w_ret_end;
   logic              w_push;
   logic [CHAR_W-1:0] w_push_data;
   logic [1:0]        w_count;
   logic [2:0]        w_occ;
   logic              w_hold_busy;
   logic              w_issue;
   logic              w_drained;

   assign w_active  = (r_state == StFetch) || (r_state == StStream);
   assign w_pop     = o_char_valid && i_char_ready;
   assign w_ret     = w_active && r_inflight;
   assign w_ret_nul = (i_rom_data == CHAR_NUL);
   assign w_ret_end = w_ret && (w_ret_nul || r_inflight_last);

`ifdef HTML_WS_COLLAPSE_EN
   logic              r_pending;
   logic              r_seen_char;
   logic              r_hold_valid;
   logic [CHAR_W-1:0] r_hold;
   logic              w_ret_ws;

   assign w_ret_ws = is_ws(i_rom_data);

   // A pending space goes out first; the byte that released it waits in r_hold.
   always_comb begin
      w_push      = 1'b0;
      w_push_data = i_rom_data;
      if (r_hold_valid) begin
         w_push      = 1'b1;
         w_push_data = r_hold;
      end else if (w_ret && !w_ret_nul && !w_ret_ws) begin
         w_push      = 1'b1;
         w_push_data = r_pending ? CHAR_SP : i_rom_data;
      end
   end

   always_ff @(posedge i_clock or negedge i_resetn) begin
      if (!i_resetn) begin
         r_pending    <= 1'b0;
         r_seen_char  <= 1'b0;
         r_hold_valid <= 1'b0;
         r_hold       <= '0;
      end else if (i_start) begin
         r_pending    <= 1'b0;
         r_seen_char  <= 1'b0;
         r_hold_valid <= 1'b0;
      end else begin
         r_hold_valid <= 1'b0;
         if (w_ret && !w_ret_nul) begin
            if (w_ret_ws) begin
               r_pending <= r_seen_char && !r_inflight_last;
            end else begin
               r_seen_char <= 1'b1;
               r_pending   <= 1'b0;
               if (r_pending) begin
                  r_hold_valid <= 1'b1;
                  r_hold       <= i_rom_data;
               end
            end
         end else if (w_ret_end) begin
            r_pending <= 1'b0;
         end
      end
   end

   // Pending space reserves a slot so the releasing byte always finds room.
   assign w_occ       = 3'(w_count) + 3'(r_inflight) + 3'(r_hold_valid) + 3'(r_pending);
   assign w_hold_busy = r_hold_valid;
`else
   assign w_push      = w_ret && !w_ret_nul;
   assign w_push_data = i_rom_data;
   assign w_occ       = 3'(w_count) + 3'(r_inflight);
   assign w_hold_busy = 1'b0;
`endif

   assign w_issue   = w_active && !i_start && !r_end_seen && !w_ret_end && !r_last_issued
                      && ((w_occ - 3'(w_pop)) < 3'd2);
   assign w_drained = r_end_seen && (w_count == 2'd0) && !r_inflight && !w_hold_busy;

   always_ff @(posedge i_clock or negedge i_resetn) begin
      if (!i_resetn) begin
         r_state         <= StIdle;
         r_addr          <= '0;
         r_inflight      <= 1'b0;
         r_inflight_last <= 1'b0;
         r_last_issued   <= 1'b0;
         r_end_seen      <= 1'b0;
         r_eof           <= 1'b0;
         r_busy          <= 1'b0;
      end else if (i_start) begin
         r_state         <= StFetch;
         r_addr          <= '0;
         r_inflight      <= 1'b0;
         r_inflight_last <= 1'b0;
         r_last_issued   <= 1'b0;
         r_end_seen      <= 1'b0;
         r_eof           <= 1'b0;
         r_busy          <= 1'b1;
      end else begin
         r_inflight      <= w_issue;
         r_inflight_last <= w_issue && (r_addr == LAST_ADDR);
         if (w_issue) begin
            // Address parks on the last location instead of wrapping.
            if (r_addr == LAST_ADDR) r_last_issued <= 1'b1;
            else                     r_addr        <= r_addr + 1'b1;
         end
         if (w_ret_end) r_end_seen <= 1'b1;
         if (w_active && w_drained) begin
            r_state <= StDone;
            r_eof   <= 1'b1;
            r_busy  <= 1'b0;
         end else if ((r_state == StFetch) && w_push) begin
            r_state <= StStream;
         end
      end
   end

   char_fifo2 #(
      .W (CHAR_W)
   ) u_fifo (
      .i_clk   (i_clock),
      .i_rst_n (i_resetn),
      .i_flush (i_start),
      .i_push  (w_push),
      .i_data  (w_push_data),
      .i_pop   (w_pop),
      .o_data  (o_char),
      .o_valid (o_char_valid),
      .o_count (w_count)
   );

   assign o_rom_addr = r_addr;
   assign o_eof      = r_eof;
   assign o_busy     = r_busy;

endmodule

// File: tb/tb_html_char_streamer.sv
// Directed bench for html_char_streamer (DOC_LEN=16) with a 1-cycle synchronous ROM model.
module tb_html_char_streamer;

   logic        clk = 1'b0;
   logic        resetn;
   logic        start;
   logic [11:0] rom_addr;
   logic [7:0]  rom_data = 8'h00;
   logic [7:0]  ch;
   logic        char_valid;
   logic        char_ready;
   logic        eof;
   logic        busy;

   logic [7:0]  rom [0:4095];
   logic [7:0]  got_q [$];
   int          n_cmp = 0;
   int          n_err = 0;
   int          first_c, last_c, eof_c, max_addr;

   always #5 clk = ~clk;

   always @(posedge clk) rom_data <= rom[rom_addr];

   html_char_streamer #(
      .CHAR_W  (8),
      .ADDR_W  (12),
      .DOC_LEN (16)
   ) dut (
      .i_clock      (clk),
      .i_resetn     (resetn),
      .i_start      (start),
      .o_rom_addr   (rom_addr),
      .i_rom_data   (rom_data),
      .o_char       (ch),
      .o_char_valid (char_valid),
      .i_char_ready (char_ready),
      .o_eof        (eof),
      .o_busy       (busy)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic load_str(input string s);
      for (int i = 0; i < 4096; i++) rom[i] = 8'h00;
      for (int i = 0; i < s.len(); i++) rom[i] = s[i];
   endtask

   // Caller is at a negedge; returns at the negedge right after the start edge.
   task automatic pulse_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   // mode 0: ready always high; mode 1: ready pattern 1,0,0 repeating.
   task automatic stream(input int mode, input int budget, input int max_acc,
                         output int f_c, output int l_c, output int e_c, output int m_a);
      logic       stalled;
      logic [7:0] prev;
      f_c = -1; l_c = -1; e_c = -1; m_a = 0;
      stalled = 1'b0;
      prev = 8'h00;
      for (int c = 0; c < budget; c++) begin
         if (int'(rom_addr) > m_a) m_a = int'(rom_addr);
         if (stalled) begin
            check_eq("stall_valid", 32'(char_valid), 32'd1);
            check_eq("stall_char", 32'(ch), 32'(prev));
         end
         if (eof) begin
            e_c = c;
            break;
         end
         if (char_valid && f_c < 0) f_c = c;
         char_ready = (mode == 0) ? 1'b1 : ((c % 3) == 0);
         if (char_valid && char_ready) begin
            got_q.push_back(ch);
            l_c = c;
         end
         stalled = char_valid && !char_ready;
         prev = ch;
         if (max_acc > 0 && got_q.size() == max_acc) break;
         @(negedge clk);
      end
   endtask

   task automatic check_stream(input string tag, input string exp);
      logic [31:0] g;
      check_eq({tag, "_count"}, 32'(got_q.size()), 32'(exp.len()));
      for (int i = 0; i < exp.len(); i++) begin
         g = (i < got_q.size()) ? 32'(got_q[i]) : 32'hFFFF_FFFF;
         check_eq({tag, "_char"}, g, 32'(exp[i]));
      end
   endtask

   task automatic check_idle_outputs(input string tag);
      check_eq({tag, "_addr"}, 32'(rom_addr), 32'd0);
      check_eq({tag, "_char"}, 32'(ch), 32'd0);
      check_eq({tag, "_valid"}, 32'(char_valid), 32'd0);
      check_eq({tag, "_eof"}, 32'(eof), 32'd0);
      check_eq({tag, "_busy"}, 32'(busy), 32'd0);
   endtask

   initial begin
      resetn = 1'b0;
      start = 1'b0;
      char_ready = 1'b0;
      load_str("<p>hi</p>");
      repeat (3) @(negedge clk);
      resetn = 1'b1;
      @(negedge clk);
      check_idle_outputs("reset");

      // 1: full-rate stream
      got_q.delete();
      pulse_start();
      check_eq("t1_busy", 32'(busy), 32'd1);
      stream(0, 60, 0, first_c, last_c, eof_c, max_addr);
      check_eq("t1_first_cycle", 32'(first_c), 32'd2);
      check_eq("t1_back_to_back", 32'(last_c - first_c), 32'd8);
      check_stream("t1", "<p>hi</p>");
      check_eq("t1_eof_seen", 32'(eof_c >= 0), 32'd1);
      check_eq("t1_eof_valid", 32'(char_valid), 32'd0);
      check_eq("t1_eof_busy", 32'(busy), 32'd0);

      // 2: stalled consumer
      got_q.delete();
      pulse_start();
      check_eq("t2_eof_cleared", 32'(eof), 32'd0);
      stream(1, 120, 0, first_c, last_c, eof_c, max_addr);
      check_stream("t2", "<p>hi</p>");
      check_eq("t2_eof", 32'(eof), 32'd1);

      // 4: NUL at address 0
      load_str("");
      got_q.delete();
      pulse_start();
      stream(0, 20, 0, first_c, last_c, eof_c, max_addr);
      check_eq("t4_never_valid", 32'(first_c), 32'hFFFF_FFFF);
      check_eq("t4_eof_by_3", 32'(eof_c >= 0 && eof_c <= 3), 32'd1);

      // 3: no terminator, length limit of 16
      for (int i = 0; i < 4096; i++) rom[i] = "a";
      got_q.delete();
      pulse_start();
      stream(0, 80, 0, first_c, last_c, eof_c, max_addr);
      check_stream("t3", "aaaaaaaaaaaaaaaa");
      check_eq("t3_max_addr", 32'(max_addr), 32'd15);
      check_eq("t3_eof", 32'(eof), 32'd1);

      // 5: restart mid-stream, then asynchronous reset mid-stream
      load_str("<p>hi</p>");
      got_q.delete();
      pulse_start();
      stream(0, 40, 3, first_c, last_c, eof_c, max_addr);
      @(negedge clk);
      char_ready = 1'b0;
      check_stream("t5_pre", "<p>");
      got_q.delete();
      pulse_start();
      check_eq("t5_valid_drop", 32'(char_valid), 32'd0);
      stream(0, 60, 0, first_c, last_c, eof_c, max_addr);
      check_eq("t5_restart_cycle", 32'(first_c), 32'd2);
      check_stream("t5_restart", "<p>hi</p>");
      got_q.delete();
      pulse_start();
      stream(0, 40, 4, first_c, last_c, eof_c, max_addr);
      #2 resetn = 1'b0;
      #1 check_idle_outputs("t5_async_reset");
      @(negedge clk);
      resetn = 1'b1;
      @(negedge clk);
      check_idle_outputs("t5_after_reset");

`ifdef HTML_WS_COLLAPSE_EN
      // 6: whitespace collapse
      load_str("  a \n\t b  ");
      got_q.delete();
      pulse_start();
      stream(0, 80, 0, first_c, last_c, eof_c, max_addr);
      check_stream("t6_ws", "a b");
      check_eq("t6_eof", 32'(eof), 32'd1);
`else
      // 6: whitespace passes through untouched
      load_str("a \tb");
      got_q.delete();
      pulse_start();
      stream(0, 80, 0, first_c, last_c, eof_c, max_addr);
      check_stream("t6_ws", "a \tb");
      check_eq("t6_eof", 32'(eof), 32'd1);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
